ysyx_24120013_ifu: RTL and testbench
====================================

# ysyx_24120013_ifu

Instruction fetch unit for the single-issue NPC core; the producer end of the decode unit's `inst` input. It holds the PC, issues one word-aligned fetch at a time on a valid/ready memory request channel, captures the response, and presents `{pc, inst}` to decode under a valid/ready handshake. It supports redirects (jump/branch) from execute, access faults, and a halt request raised by the `ebreak`/halt path.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC and fetch address width.
- `DATA_WIDTH`, 32: instruction word width.
- `RESET_PC`, 32'h8000_0000: first fetch address.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous assert, active-low (0 = reset).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  ADDR_WIDTH  fetch address; always equals current PC.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response valid; single-cycle pulse, no back-pressure.
- `imem_rsp_data`  in  DATA_WIDTH  fetched word.
- `imem_rsp_err`  in  1  access error, qualified by `imem_rsp_valid`.
- `IFU_inst_valid`  out  1  instruction presented to decode.
- `IFU_inst`  out  DATA_WIDTH  instruction word.
- `IFU_pc`  out  ADDR_WIDTH  PC of `IFU_inst`.
- `IFU_fault`  out  1  presented entry is a fault (`IFU_inst` = 0).
- `IFU_inst_ready`  in  1  decode accepts the entry.
- `redirect_valid`  in  1  redirect pulse from execute.
- `redirect_pc`  in  ADDR_WIDTH  redirect target.
- `halt_req`  in  1  stop fetching (level or pulse, sampled).

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT. Reset state is IDLE.
- IDLE: unconditionally moves to REQ on the next edge.
- REQ: `imem_req_valid` = 1. On `valid & ready`, move to WAIT.
- WAIT: on a response, latch data, err and PC into the output register, then move to HOLD.
- HOLD: `IFU_inst_valid` = 1. On `IFU_inst_ready`, set PC to PC+4 (modulo 2^ADDR_WIDTH, wraps silently) and move to REQ. If the accepted entry had `IFU_fault` set, move to HALT instead.
- HALT: no requests and no valid output. Only reset exits HALT.
- Redirect has priority over sequential increment in every state:
  - In REQ without a handshake: load PC from `redirect_pc` and stay in REQ. This changes the address while valid is high; that is permitted as a flush.
  - In REQ with a handshake in the same cycle: the request is issued and marked stale, and the target is saved.
  - In WAIT: mark stale and save the target. When the stale response arrives, discard it (no HOLD), load the target, and go to REQ.
  - In HOLD: drop the held entry even if `IFU_inst_ready`, load the target, and go to REQ.
  - In IDLE/HALT: ignored.
- Misalignment: `redirect_pc[1:0] != 0` produces a fault entry in HOLD with `IFU_pc` = the target and no memory access.
- A response with `imem_rsp_err` produces a fault entry.
- `halt_req`:
  - In REQ without a handshake, or in HOLD: go to HALT immediately and drop any held entry.
  - In WAIT: complete and discard the response, then go to HALT.
  - Redirect and `halt_req` in the same cycle: halt wins.
- Only one request is ever outstanding. A response outside WAIT is a protocol error and is ignored.

## Timing
- Reset values:
  - `imem_req_valid` = 0, `IFU_inst_valid` = 0, `IFU_fault` = 0.
  - `IFU_inst` = 0, `IFU_pc` = RESET_PC, `imem_req_addr` = RESET_PC.
  - Stale flag = 0.
- Reset asserted mid-operation aborts everything immediately. An in-flight response arriving after release is ignored, because the state is not WAIT.
- First `imem_req_valid` is high in the second cycle after reset release (one IDLE cycle).
- Sequential fetch throughput, with zero-wait ready and a 1-cycle response: one instruction per 3 cycles (REQ, WAIT, HOLD).
- `IFU_inst_valid` rises the cycle after `imem_rsp_valid`.
- All outputs are registered or decoded from the state only; there are no combinational paths from inputs to outputs.
- Output stability: `IFU_inst`, `IFU_pc` and `IFU_fault` hold while `IFU_inst_valid & !IFU_inst_ready`, unless a redirect or halt arrives.

## Structure
- The shared package `ysyx_24120013_pkg` holds:
  - the state encoding (IDLE, REQ, WAIT, HOLD, HALT);
  - the `RESET_PC` default;
  - the PC increment constant (4).
- Sub-module `ysyx_24120013_ifu_pc`: the PC register, the redirect-target and stale-flag registers, and the next-PC mux (redirect / +4 / hold), plus the misalignment check.
- The FSM and the output register live in the top module.

## Test plan
- Reset, then a zero-latency memory returning 0x00000013 for 4 accepts → `imem_req_addr` sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C; `IFU_inst_valid` every 3rd cycle; `IFU_pc` matches each address.
- Decode back-pressure: `IFU_inst_ready` = 0 for 5 cycles in HOLD → outputs stable, no new request; then accept → next request goes to PC+4.
- Redirect to 0x80000100 in WAIT: the stale response 0xDEADBEEF is never presented; the next request goes to 0x80000100. Redirect to 0x80000102 → fault entry with `IFU_pc` = 0x80000102 and no request, then HALT.
- `imem_rsp_err` = 1 at 0x80000008 → `IFU_fault` = 1 and `IFU_inst` = 0; after the accept, no further `imem_req_valid`.
- `halt_req` pulse in WAIT → response discarded, `IFU_inst_valid` stays 0, HALT is held for 20 cycles. `halt_req` together with a redirect → HALT.
- PC wrap: redirect to 0xFFFFFFFC, accept → next request at 0x00000000. Async reset asserted mid-WAIT → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_24120013_pkg.sv
// Shared IFU definitions: FSM encoding, next-PC select, reset PC and fetch stride.
package ysyx_24120013_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_KEEP,
        PC_INC,
        PC_TGT
    } pc_sel_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ysyx_24120013_ifu_if.sv
// IFU channels: imem request/response, decode handoff, redirect and halt controls.
interface ysyx_24120013_ifu_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  imem_rsp_err;
    logic                  IFU_inst_valid;
    logic [DATA_WIDTH-1:0] IFU_inst;
    logic [ADDR_WIDTH-1:0] IFU_pc;
    logic                  IFU_fault;
    logic                  IFU_inst_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt_req;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output IFU_inst_valid, IFU_inst, IFU_pc, IFU_fault,
        input  IFU_inst_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  IFU_inst_valid, IFU_inst, IFU_pc, IFU_fault,
        output IFU_inst_ready, redirect_valid, redirect_pc, halt_req
    );

endinterface

// File: rtl/ysyx_24120013_ifu_pc.sv
// PC, saved redirect target and stale flag; next PC is keep / +4 / target.
// The effective target is the live redirect when present, otherwise the saved one.
module ysyx_24120013_ifu_pc
    import ysyx_24120013_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  pc_sel_e               pc_sel_i,
    input  logic                  redir_vld_i,
    input  logic [ADDR_WIDTH-1:0] redir_pc_i,
    input  logic                  stale_set_i,
    input  logic                  stale_clr_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] tgt_o,
    output logic                  tgt_misaligned_o,
    output logic                  stale_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tgt_q;
    logic                  stale_q, stale_d;

    always_comb begin
        tgt_o = redir_vld_i ? redir_pc_i : tgt_q;
        pc_d  = pc_q;
        case (pc_sel_i)
            PC_INC:  pc_d = pc_q + STEP;
            PC_TGT:  pc_d = tgt_o;
            default: pc_d = pc_q;
        endcase
        // Consuming a response retires the stale mark even if a new redirect lands that cycle.
        if (stale_clr_i) begin
            stale_d = 1'b0;
        end else if (stale_set_i) begin
            stale_d = 1'b1;
        end else begin
            stale_d = stale_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            stale_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_o;
            stale_q <= stale_d;
        end
    end

    assign pc_o             = pc_q;
    assign tgt_misaligned_o = |tgt_o[1:0];
    assign stale_o          = stale_q;

endmodule

// File: rtl/ysyx_24120013_ifu.sv
// Fetch FSM (IDLE/REQ/WAIT/HOLD/HALT) with a registered {pc, inst, fault} entry for decode.
// One fetch outstanding; 3 cycles per instruction at zero wait; outputs depend on state/registers only.
module ysyx_24120013_ifu
    import ysyx_24120013_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_24120013_ifu_if.master bus
);

    ifu_state_e            state_q, state_d;
    logic                  halt_pend_q, halt_pend_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;
    logic                  fault_q, fault_d;

    pc_sel_e               pc_sel;
    logic                  stale_set, stale_clr, take_tgt;
    logic [ADDR_WIDTH-1:0] pc, tgt;
    logic                  tgt_mis, stale;

    ysyx_24120013_ifu_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk              (clk),
        .rst_n            (rst),
        .pc_sel_i         (pc_sel),
        .redir_vld_i      (bus.redirect_valid),
        .redir_pc_i       (bus.redirect_pc),
        .stale_set_i      (stale_set),
        .stale_clr_i      (stale_clr),
        .pc_o             (pc),
        .tgt_o            (tgt),
        .tgt_misaligned_o (tgt_mis),
        .stale_o          (stale)
    );

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        inst_d      = inst_q;
        opc_d       = opc_q;
        fault_d     = fault_q;
        pc_sel      = PC_KEEP;
        stale_set   = 1'b0;
        stale_clr   = 1'b0;
        take_tgt    = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d     = ST_WAIT;
                    halt_pend_d = bus.halt_req;
                    stale_set   = bus.redirect_valid & ~bus.halt_req;
                end else if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.redirect_valid) begin
                    take_tgt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    stale_clr   = 1'b1;
                    halt_pend_d = 1'b0;
                    if (halt_pend_q | bus.halt_req) begin
                        state_d = ST_HALT;
                    end else if (stale | bus.redirect_valid) begin
                        take_tgt = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        inst_d  = bus.imem_rsp_err ? '0 : bus.imem_rsp_data;
                        opc_d   = pc;
                        fault_d = bus.imem_rsp_err;
                    end
                end else begin
                    stale_set = bus.redirect_valid & ~bus.halt_req & ~halt_pend_q;
                end
            end
            ST_HOLD: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.redirect_valid) begin
                    take_tgt = 1'b1;
                end else if (bus.IFU_inst_ready) begin
                    if (fault_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_sel  = PC_INC;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // A misaligned target never reaches memory; it becomes a fault entry directly.
        if (take_tgt) begin
            pc_sel = PC_TGT;
            if (tgt_mis) begin
                state_d = ST_HOLD;
                inst_d  = '0;
                opc_d   = tgt;
                fault_d = 1'b1;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            halt_pend_q <= 1'b0;
            inst_q      <= '0;
            opc_q       <= RESET_PC;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.IFU_inst_valid = (state_q == ST_HOLD);
    assign bus.IFU_inst       = inst_q;
    assign bus.IFU_pc         = opc_q;
    assign bus.IFU_fault      = fault_q;

endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// Directed and randomized checks of the IFU against a transaction-level fetch model.
module tb_ysyx_24120013_ifu;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_24120013_ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_24120013_ifu #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = '0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_word = '0;
    logic [31:0] err_addr = 32'h1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F17;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock; the memory model answers accepted requests after mem_lat+1 cycles.
    task automatic tick();
        bit          hs;
        logic [31:0] a;
        hs = (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
        a  = bus.imem_req_addr;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        if (hs) begin
            req_cnt++;
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = a;
        end
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = use_fixed ? fixed_word : mem_word(mem_addr);
                bus.imem_rsp_err   = (mem_addr == err_addr);
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_pend = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.IFU_inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.halt_req       = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_req(output bit saw_inst);
        int n = 0;
        saw_inst = 1'b0;
        while (bus.imem_req_valid !== 1'b1 && n < 16) begin
            if (bus.IFU_inst_valid === 1'b1) saw_inst = 1'b1;
            tick();
            n++;
        end
        chk1("req_timeout", bus.imem_req_valid, 1'b1);
    endtask

    task automatic wait_inst();
        int n = 0;
        while (bus.IFU_inst_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk1("inst_timeout", bus.IFU_inst_valid, 1'b1);
    endtask

    initial begin
        logic [31:0] mpc, tgt;
        bit          saw;
        int          rc;

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.IFU_inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt_req       = 1'b0;

        // Reset values
        tick();
        tick();
        chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk1("rst_inst_valid", bus.IFU_inst_valid, 1'b0);
        chk1("rst_fault", bus.IFU_fault, 1'b0);
        chk("rst_inst", bus.IFU_inst, 32'h0);
        chk("rst_pc", bus.IFU_pc, 32'h8000_0000);
        chk("rst_addr", bus.imem_req_addr, 32'h8000_0000);
        rst = 1'b1;
        chk1("idle_no_req", bus.imem_req_valid, 1'b0);
        bus.imem_req_ready = 1'b1;
        bus.IFU_inst_ready = 1'b1;
        mem_lat = 0;
        use_fixed = 1'b1;
        fixed_word = 32'h0000_0013;
        tick();
        chk1("first_req", bus.imem_req_valid, 1'b1);

        // Sequential fetch, one instruction every 3 cycles
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", bus.imem_req_addr, 32'h8000_0000 + 32'(4 * k));
            chk1("seq_req_cyc", bus.IFU_inst_valid, 1'b0);
            tick();
            chk1("seq_wait_req", bus.imem_req_valid, 1'b0);
            chk1("seq_wait_vld", bus.IFU_inst_valid, 1'b0);
            tick();
            chk1("seq_hold_vld", bus.IFU_inst_valid, 1'b1);
            chk("seq_inst", bus.IFU_inst, 32'h0000_0013);
            chk("seq_pc", bus.IFU_pc, 32'h8000_0000 + 32'(4 * k));
            chk1("seq_fault", bus.IFU_fault, 1'b0);
            tick();
        end

        // Decode back-pressure
        bus.IFU_inst_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("bp_vld", bus.IFU_inst_valid, 1'b1);
            chk("bp_pc", bus.IFU_pc, 32'h8000_0010);
            chk("bp_inst", bus.IFU_inst, 32'h0000_0013);
            chk1("bp_no_req", bus.imem_req_valid, 1'b0);
            if (i == 4) bus.IFU_inst_ready = 1'b1;
            tick();
        end
        chk1("bp_next_req", bus.imem_req_valid, 1'b1);
        chk("bp_next_addr", bus.imem_req_addr, 32'h8000_0014);

        // Redirect during WAIT discards the stale response
        fixed_word = 32'hDEAD_BEEF;
        mem_lat = 2;
        tick();
        chk1("rw_in_wait", bus.imem_req_valid, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick();
        chk1("rw_no_vld0", bus.IFU_inst_valid, 1'b0);
        tick();
        chk1("rw_no_vld1", bus.IFU_inst_valid, 1'b0);
        tick();
        chk1("rw_no_vld2", bus.IFU_inst_valid, 1'b0);
        chk1("rw_req", bus.imem_req_valid, 1'b1);
        chk("rw_addr", bus.imem_req_addr, 32'h8000_0100);
        use_fixed = 1'b0;
        mem_lat = 0;
        tick();
        tick();
        chk1("rw_tgt_vld", bus.IFU_inst_valid, 1'b1);
        chk("rw_tgt_inst", bus.IFU_inst, mem_word(32'h8000_0100));
        chk("rw_tgt_pc", bus.IFU_pc, 32'h8000_0100);

        // Misaligned redirect in HOLD: fault entry, no access, then HALT
        rc = req_cnt;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        tick();
        chk1("mis_vld", bus.IFU_inst_valid, 1'b1);
        chk1("mis_fault", bus.IFU_fault, 1'b1);
        chk("mis_inst", bus.IFU_inst, 32'h0);
        chk("mis_pc", bus.IFU_pc, 32'h8000_0102);
        chk1("mis_no_req", bus.imem_req_valid, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("mis_halt_req", bus.imem_req_valid, 1'b0);
            chk1("mis_halt_vld", bus.IFU_inst_valid, 1'b0);
            tick();
        end
        chk("mis_req_cnt", 32'(req_cnt), 32'(rc));

        // Access error at the third fetch
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.IFU_inst_ready = 1'b1;
        err_addr = 32'h8000_0008;
        for (int k = 0; k < 2; k++) begin
            chk("err_pre_addr", bus.imem_req_addr, 32'h8000_0000 + 32'(4 * k));
            tick();
            tick();
            chk("err_pre_inst", bus.IFU_inst, mem_word(32'h8000_0000 + 32'(4 * k)));
            tick();
        end
        chk("err_addr", bus.imem_req_addr, 32'h8000_0008);
        tick();
        tick();
        chk1("err_vld", bus.IFU_inst_valid, 1'b1);
        chk1("err_fault", bus.IFU_fault, 1'b1);
        chk("err_inst", bus.IFU_inst, 32'h0);
        chk("err_pc", bus.IFU_pc, 32'h8000_0008);
        tick();
        rc = req_cnt;
        for (int i = 0; i < 5; i++) begin
            chk1("err_halt_req", bus.imem_req_valid, 1'b0);
            tick();
        end
        chk("err_req_cnt", 32'(req_cnt), 32'(rc));
        err_addr = 32'h1;

        // halt_req pulse during WAIT
        do_reset();
        mem_lat = 1;
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        chk1("hw_no_vld", bus.IFU_inst_valid, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("hw_halted", {30'h0, bus.imem_req_valid, bus.IFU_inst_valid}, 32'h0);
            tick();
        end

        // halt_req together with redirect
        do_reset();
        bus.halt_req       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        tick();
        bus.halt_req = 1'b0;
        chk("hr_addr", bus.imem_req_addr, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            chk1("hr_halted", bus.imem_req_valid, 1'b0);
            tick();
        end

        // PC wrap
        do_reset();
        mem_lat = 0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        chk1("wrap_req", bus.imem_req_valid, 1'b1);
        chk("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        bus.IFU_inst_ready = 1'b1;
        tick();
        tick();
        chk("wrap_pc", bus.IFU_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", bus.IFU_inst, mem_word(32'hFFFF_FFFC));
        tick();
        chk("wrap_next", bus.imem_req_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of WAIT
        mem_lat = 3;
        tick();
        bus.imem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk1("ar_req_valid", bus.imem_req_valid, 1'b0);
        chk1("ar_inst_valid", bus.IFU_inst_valid, 1'b0);
        chk1("ar_fault", bus.IFU_fault, 1'b0);
        chk("ar_inst", bus.IFU_inst, 32'h0);
        chk("ar_pc", bus.IFU_pc, 32'h8000_0000);
        chk("ar_addr", bus.imem_req_addr, 32'h8000_0000);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("ar_late_rsp", bus.IFU_inst_valid, 1'b0);
            chk("ar_req_addr", bus.imem_req_addr, 32'h8000_0000);
            tick();
        end

        // Randomized fetch stream: accept advances by 4, any redirect before accept jumps
        do_reset();
        mpc = 32'h8000_0000;
        for (int it = 0; it < 30; it++) begin
            wait_req(saw);
            chk1("rnd_no_stale", saw, 1'b0);
            chk("rnd_addr", bus.imem_req_addr, mpc);
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_addr_held", bus.imem_req_addr, mpc);
            mem_lat = int'($urandom_range(0, 3));
            bus.imem_req_ready = 1'b1;
            tick();
            bus.imem_req_ready = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                tgt = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = tgt;
                mpc = tgt;
                tick();
                continue;
            end
            wait_inst();
            chk("rnd_pc", bus.IFU_pc, mpc);
            chk("rnd_inst", bus.IFU_inst, mem_word(mpc));
            chk1("rnd_fault", bus.IFU_fault, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                tgt = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = tgt;
                bus.IFU_inst_ready = 1'($urandom_range(0, 1));
                mpc = tgt;
                tick();
                bus.IFU_inst_ready = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) tick();
                chk("rnd_stall_pc", bus.IFU_pc, mpc);
                bus.IFU_inst_ready = 1'b1;
                tick();
                bus.IFU_inst_ready = 1'b0;
                mpc = mpc + 32'd4;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
